parking_lane_ctrl: RTL

- Downstream consumer of the per-lane IR presence detectors.
- Takes the debounced "car present" levels from the entry-lane and exit-lane sensor stages and runs a barrier-gate state machine per lane.
- Keeps the lot occupancy count and flags full / rejected arrivals.
- Its outputs drive the gate actuators, the occupancy display and the status LEDs.

---
 rtl/parking_lane_ctrl.sv | 195 +++++++++++++++++++
 1 files changed

// File: rtl/parking_lane_ctrl.sv
// Parking lot lane controller: per-lane barrier FSMs plus occupancy count.
// Optional PARK_PRESET_EN adds a preset_load/preset_val count override.

module parking_lane_fsm #(
    parameter int GATE_MS = 3000,
    parameter int TMR_W   = 12
) (
    input  logic clk,
    input  logic rst_n,
    input  logic tick,
    input  logic det,
    input  logic blocked,
    output logic gate,
    output logic commit,
    output logic refuse
);

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        HOLD,
        REFUSE
    } state_t;

    localparam logic [TMR_W-1:0] HOLD_LD = TMR_W'(GATE_MS);
    localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

    state_t state;
    state_t state_nxt;
    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;
    logic det_q;
    logic rise;
    logic fall;

    assign rise = det & ~det_q;
    assign fall = ~det & det_q;

    // State, hold timer, sensor history and registered gate drive
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tmr   <= '0;
            det_q <= 1'b0;
            gate  <= 1'b0;
        end else begin
            state <= state_nxt;
            tmr   <= tmr_nxt;
            det_q <= det;
            gate  <= (state_nxt == OPEN) || (state_nxt == HOLD);
        end
    end

    // Next-state, timer and commit/refuse decode
    always_comb begin
        state_nxt = state;
        tmr_nxt   = tmr;
        commit    = 1'b0;
        refuse    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rise) begin
                    if (blocked) begin
                        state_nxt = REFUSE;
                        refuse    = 1'b1;
                    end else begin
                        state_nxt = OPEN;
                    end
                end
            end
            OPEN: begin
                if (fall) begin
                    commit    = 1'b1;
                    tmr_nxt   = HOLD_LD;
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (rise) begin
                    state_nxt = OPEN;
                end else if (tick) begin
                    if (tmr == TMR_ONE) begin
                        tmr_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        tmr_nxt = tmr - TMR_ONE;
                    end
                end
            end
            REFUSE: begin
                if (fall) begin
                    state_nxt = IDLE;
                end
            end
        endcase
    end

endmodule

module parking_lane_ctrl #(
    parameter int CAPACITY = 8,
    parameter int CNT_W    = 4,
    parameter int GATE_MS  = 3000,
    parameter int TMR_W    = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick_ms,
    input  logic             entry_det,
    input  logic             exit_det,
`ifdef PARK_PRESET_EN
    input  logic             preset_load,
    input  logic [CNT_W-1:0] preset_val,
`endif
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             entry_gate,
    output logic             exit_gate,
    output logic             entry_evt,
    output logic             exit_evt,
    output logic             reject
);

    localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    logic in_commit;
    logic out_commit;
    logic in_refuse;
    logic out_refuse;
    logic empty;
    logic [CNT_W-1:0] count_nxt;

    assign full  = (count == CAP);
    assign empty = (count == '0);

    parking_lane_fsm #(
        .GATE_MS (GATE_MS),
        .TMR_W   (TMR_W)
    ) u_entry (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick_ms),
        .det     (entry_det),
        .blocked (full),
        .gate    (entry_gate),
        .commit  (in_commit),
        .refuse  (in_refuse)
    );

    parking_lane_fsm #(
        .GATE_MS (GATE_MS),
        .TMR_W   (TMR_W)
    ) u_exit (
        .clk     (clk),
        .rst_n   (rst_n),
        .tick    (tick_ms),
        .det     (exit_det),
        .blocked (empty),
        .gate    (exit_gate),
        .commit  (out_commit),
        .refuse  (out_refuse)
    );

    // Saturating occupancy update; simultaneous in/out cancels
    always_comb begin
        count_nxt = count;
        if (in_commit && !out_commit && (count < CAP)) begin
            count_nxt = count + ONE;
        end else if (out_commit && !in_commit && !empty) begin
            count_nxt = count - ONE;
        end
`ifdef PARK_PRESET_EN
        if (preset_load) begin
            count_nxt = (preset_val > CAP) ? CAP : preset_val;
        end
`endif
    end

    // Occupancy register and registered event pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count     <= '0;
            entry_evt <= 1'b0;
            exit_evt  <= 1'b0;
            reject    <= 1'b0;
        end else begin
            count     <= count_nxt;
            entry_evt <= in_commit;
            exit_evt  <= out_commit;
            reject    <= in_refuse | out_refuse;
        end
    end

endmodule
